// File: rtl/ram_arbiter_pkg.sv
// Shared encodings and bus widths for the single-port SRAM arbiter.
package ram_arbiter_pkg;

  localparam int RAM_ADDR_BUS = 18;
  localparam int RAM_DATA_BUS = 16;

  localparam logic PAUSE_ENABLE  = 1'b1;
  localparam logic PAUSE_DISABLE = 1'b0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    WR_SETUP  = 3'd2,
    WR_STROBE = 3'd3,
    WR_HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/ram_arbiter.sv
// SRAM arbiter: serves an instruction fetch every free cycle and sequences
// multi-cycle data loads/stores, stalling the fetch stage while they run.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_BUS,
  parameter int DATA_W   = RAM_DATA_BUS,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              ram_pause,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_dq_oe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_PULSE - 1);

  state_t              state, state_n;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W-1:0]   inst_q;
  logic                we_n_q, oe_n_q, dq_oe_q;
  logic                strobe, in_idle, rd_last, wr_next;

  assign strobe  = mem_rd | mem_wr;
  assign in_idle = (state == IDLE);
  assign rd_last = (state == RD) && (cnt == RD_LAST);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (mem_wr) state_n = WR_SETUP;
                 else if (mem_rd) state_n = RD;
      RD:        if (cnt == RD_LAST) state_n = IDLE;
      WR_SETUP:  state_n = WR_STROBE;
      WR_STROBE: if (cnt == WR_LAST) state_n = WR_HOLD;
      WR_HOLD:   state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  assign wr_next = (state_n == WR_SETUP) || (state_n == WR_STROBE) || (state_n == WR_HOLD);

  // NOTE: registers update with <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      inst_q    <= '0;
      mem_rdata <= '0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b0;
      dq_oe_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= ((state_n == state) && (state == RD || state == WR_STROBE)) ? cnt + 4'd1 : 4'd0;
      if (in_idle && strobe) begin
        req_addr <= mem_addr;
        if (mem_wr) req_wdata <= mem_wdata;
      end
      if (in_idle && !strobe) inst_q <= ram_din;
      if (rd_last) mem_rdata <= ram_din;
      // Strobes come from the next state so they switch on the same edge as the address/bus.
      we_n_q  <= (state_n != WR_STROBE);
      oe_n_q  <= wr_next;
      dq_oe_q <= wr_next;
    end
  end

  assign ram_pause = (!in_idle || strobe) ? PAUSE_ENABLE : PAUSE_DISABLE;
  assign if_inst   = (in_idle && !strobe) ? ram_din : inst_q;
  assign ram_addr  = in_idle ? if_addr : req_addr;
  assign ram_dout  = dq_oe_q ? req_wdata : '0;
  assign mem_done  = rd_last || (state == WR_HOLD);
  assign ram_dq_oe = dq_oe_q;
  assign ram_ce_n  = 1'b0;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural SRAM (RD_WAIT=2, WR_PULSE=1).
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] if_addr, mem_addr, ram_addr;
  logic [15:0] if_inst, mem_wdata, mem_rdata, ram_dout, ram_din;
  logic        mem_rd, mem_wr, mem_done, ram_pause;
  logic        ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] sram [0:(1<<18)-1];

  always #5 clk = ~clk;

  assign ram_din = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr] : 16'h0000;

  always @(posedge clk) begin
    if (!ram_we_n && ram_dq_oe) sram[ram_addr] <= ram_dout;
  end

  ram_arbiter #(.ADDR_W(18), .DATA_W(16), .RD_WAIT(2), .WR_PULSE(1)) dut (
    .clk(clk), .rst(rst),
    .if_addr(if_addr), .if_inst(if_inst),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .ram_pause(ram_pause),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
    .ram_dq_oe(ram_dq_oe), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; checks happen 1 ns after the falling edge.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic strobe_clear();
    mem_rd = 1'b0;
    mem_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    if_addr = 18'h00010;
    mem_rd = 1'b0; mem_wr = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    sram[18'h00010] = 16'h4A05;
    sram[18'h00011] = 16'h1111;
    sram[18'h0BF00] = 16'h1234;
    sram[18'h0BF01] = 16'h0000;
    sram[18'h0BF02] = 16'h0000;
    sram[18'h0BF03] = 16'h0000;

    next_cycle();
    check("rst_we_n",      32'(ram_we_n),  32'h1);
    check("rst_dq_oe",     32'(ram_dq_oe), 32'h0);
    check("rst_mem_done",  32'(mem_done),  32'h0);
    check("rst_mem_rdata", 32'(mem_rdata), 32'h0);
    check("rst_pause",     32'(ram_pause), 32'h0);
    rst = 1'b1;

    // Fetch only
    next_cycle();
    check("fetch_inst",  32'(if_inst),   32'h4A05);
    check("fetch_pause", 32'(ram_pause), 32'h0);
    check("fetch_addr",  32'(ram_addr),  32'h00010);
    check("fetch_oe_n",  32'(ram_oe_n),  32'h0);
    check("fetch_dout",  32'(ram_dout),  32'h0);
    if_addr = 18'h00011;
    #1;
    check("fetch_inst2", 32'(if_inst), 32'h1111);

    // Load: strobe cycle T, done at T+2, fetch resumes at T+3
    next_cycle();
    mem_rd = 1'b1; mem_addr = 18'h0BF00;
    #1;
    check("ld_t0_pause", 32'(ram_pause), 32'h1);
    check("ld_t0_done",  32'(mem_done),  32'h0);
    check("ld_t0_inst",  32'(if_inst),   32'h1111);
    next_cycle();
    strobe_clear(); mem_addr = 18'h3FFFF;
    #1;
    check("ld_t1_pause", 32'(ram_pause), 32'h1);
    check("ld_t1_addr",  32'(ram_addr),  32'h0BF00);
    check("ld_t1_done",  32'(mem_done),  32'h0);
    check("ld_t1_inst",  32'(if_inst),   32'h1111);
    next_cycle();
    check("ld_t2_pause", 32'(ram_pause), 32'h1);
    check("ld_t2_done",  32'(mem_done),  32'h1);
    check("ld_t2_inst",  32'(if_inst),   32'h1111);
    next_cycle();
    check("ld_t3_pause", 32'(ram_pause), 32'h0);
    check("ld_t3_done",  32'(mem_done),  32'h0);
    check("ld_rdata",    32'(mem_rdata), 32'h1234);
    check("ld_t3_addr",  32'(ram_addr),  32'h00011);

    // Store: T strobe, T+1 setup, T+2 we_n low, T+3 hold + done
    next_cycle();
    mem_wr = 1'b1; mem_addr = 18'h0BF01; mem_wdata = 16'hBEEF;
    #1;
    check("st_t0_pause", 32'(ram_pause), 32'h1);
    check("st_t0_we_n",  32'(ram_we_n),  32'h1);
    check("st_t0_dq_oe", 32'(ram_dq_oe), 32'h0);
    next_cycle();
    strobe_clear(); mem_wdata = 16'h0000;
    #1;
    check("st_t1_we_n",  32'(ram_we_n),  32'h1);
    check("st_t1_dq_oe", 32'(ram_dq_oe), 32'h1);
    check("st_t1_oe_n",  32'(ram_oe_n),  32'h1);
    check("st_t1_addr",  32'(ram_addr),  32'h0BF01);
    check("st_t1_dout",  32'(ram_dout),  32'hBEEF);
    check("st_t1_pause", 32'(ram_pause), 32'h1);
    next_cycle();
    check("st_t2_we_n",  32'(ram_we_n),  32'h0);
    check("st_t2_addr",  32'(ram_addr),  32'h0BF01);
    check("st_t2_dout",  32'(ram_dout),  32'hBEEF);
    check("st_t2_done",  32'(mem_done),  32'h0);
    next_cycle();
    check("st_t3_we_n",  32'(ram_we_n),  32'h1);
    check("st_t3_addr",  32'(ram_addr),  32'h0BF01);
    check("st_t3_dout",  32'(ram_dout),  32'hBEEF);
    check("st_t3_done",  32'(mem_done),  32'h1);
    check("st_t3_pause", 32'(ram_pause), 32'h1);
    next_cycle();
    check("st_t4_pause", 32'(ram_pause), 32'h0);
    check("st_t4_dq_oe", 32'(ram_dq_oe), 32'h0);
    check("st_t4_dout",  32'(ram_dout),  32'h0);
    check("st_t4_we_n",  32'(ram_we_n),  32'h1);
    check("st_sram",     32'(sram[18'h0BF01]), 32'hBEEF);

    // Simultaneous strobes: write wins, mem_rdata untouched
    mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 18'h0BF02; mem_wdata = 16'h5A5A;
    #1;
    check("both_t0_pause", 32'(ram_pause), 32'h1);
    next_cycle();
    strobe_clear();
    #1;
    check("both_t1_oe_n",  32'(ram_oe_n),  32'h1);
    check("both_t1_dq_oe", 32'(ram_dq_oe), 32'h1);
    next_cycle();
    check("both_t2_we_n",  32'(ram_we_n),  32'h0);
    next_cycle();
    check("both_t3_done",  32'(mem_done),  32'h1);
    next_cycle();
    check("both_rdata",    32'(mem_rdata), 32'h1234);
    check("both_sram",     32'(sram[18'h0BF02]), 32'h5A5A);
    check("both_pause",    32'(ram_pause), 32'h0);

    // Store then back-to-back load of the same address
    mem_wr = 1'b1; mem_addr = 18'h0BF03; mem_wdata = 16'hC0DE;
    next_cycle();
    strobe_clear();
    next_cycle();
    next_cycle();
    check("b2b_st_done", 32'(mem_done), 32'h1);
    next_cycle();
    mem_rd = 1'b1; mem_addr = 18'h0BF03;
    #1;
    check("b2b_ld_pause", 32'(ram_pause), 32'h1);
    next_cycle();
    strobe_clear();
    #1;
    check("b2b_ld_addr",  32'(ram_addr),  32'h0BF03);
    check("b2b_ld_oe_n",  32'(ram_oe_n),  32'h0);
    next_cycle();
    check("b2b_ld_done",  32'(mem_done),  32'h1);
    next_cycle();
    check("b2b_ld_rdata", 32'(mem_rdata), 32'hC0DE);
    check("b2b_ld_pause", 32'(ram_pause), 32'h0);

    // Reset during WR_STROBE forces we_n high without a clock edge
    mem_wr = 1'b1; mem_addr = 18'h0BF00; mem_wdata = 16'hDEAD;
    next_cycle();
    strobe_clear();
    next_cycle();
    check("rstw_we_low", 32'(ram_we_n), 32'h0);
    rst = 1'b0;
    #1;
    check("rstw_we_n",   32'(ram_we_n),  32'h1);
    check("rstw_dq_oe",  32'(ram_dq_oe), 32'h0);
    check("rstw_pause",  32'(ram_pause), 32'h0);
    next_cycle();
    rst = 1'b1;
    if_addr = 18'h00010;
    next_cycle();
    check("rstw_post_pause", 32'(ram_pause), 32'h0);
    check("rstw_post_inst",  32'(if_inst),   32'h4A05);
    check("rstw_post_addr",  32'(ram_addr),  32'h00010);
    check("rstw_post_rdata", 32'(mem_rdata), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
